// File: rtl/rv_decode_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rv_decode_pkg : shared RV32 immediate-format and opcode constants       |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
package rv_decode_pkg;

   typedef logic [1:0] imm_type_t;

   localparam imm_type_t IMM_I_TYPE = 2'b00;
   localparam imm_type_t IMM_S_TYPE = 2'b01;
   localparam imm_type_t IMM_U_TYPE = 2'b10;
   localparam imm_type_t IMM_B_TYPE = 2'b11;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage
`default_nettype wire

// File: rtl/if_id_queue_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | if_id_queue_if : fetch/decode handshake bundle of the IF/ID queue       |
// | Optional: IF_ID_QUEUE_PREDECODE_EN adds out_imm_type. Revision 1.0     |
// +-----------------------------------------------------------------------+
interface if_id_queue_if #(
   parameter int INST_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
`ifdef IF_ID_QUEUE_PREDECODE_EN
   import rv_decode_pkg::*;
`endif

   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] in_pc;
   logic [INST_WIDTH-1:0] in_inst;
   logic                  out_valid;
   logic                  out_ready;
   logic [ADDR_WIDTH-1:0] out_pc;
   logic [INST_WIDTH-1:0] out_inst;
`ifdef IF_ID_QUEUE_PREDECODE_EN
   imm_type_t             out_imm_type;
`endif

   // slave: the queue itself; master: the fetch/decode environment
   modport slave (
      input  in_valid, in_pc, in_inst, out_ready,
      output in_ready, out_valid, out_pc, out_inst
`ifdef IF_ID_QUEUE_PREDECODE_EN
      , output out_imm_type
`endif
   );

   modport master (
      output in_valid, in_pc, in_inst, out_ready,
      input  in_ready, out_valid, out_pc, out_inst
`ifdef IF_ID_QUEUE_PREDECODE_EN
      , input out_imm_type
`endif
   );

endinterface
`default_nettype wire

// File: rtl/if_id_queue_predecode.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | if_id_predecode : maps an RV32 opcode to its immediate format           |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module if_id_predecode
   import rv_decode_pkg::*;
(
   input  logic [6:0] opcode,
   output imm_type_t  imm_type
);

   always_comb begin
      imm_type = IMM_I_TYPE;
      case (opcode)
         OPC_LOAD, OPC_OP_IMM, OPC_JALR: imm_type = IMM_I_TYPE;
         OPC_STORE:                      imm_type = IMM_S_TYPE;
         OPC_LUI, OPC_AUIPC:             imm_type = IMM_U_TYPE;
         OPC_BRANCH:                     imm_type = IMM_B_TYPE;
         default:                        imm_type = IMM_I_TYPE;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | if_id_queue : DEPTH-entry {pc, inst} FIFO between fetch and decode      |
// | Optional: IF_ID_QUEUE_PREDECODE_EN stores imm_type per entry. Rev 1.0  |
// +-----------------------------------------------------------------------+
module if_id_queue #(
   parameter int DEPTH      = 4,
   parameter int INST_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   if_id_queue_if.slave             q,
   output logic [$clog2(DEPTH):0]   count
);
`ifdef IF_ID_QUEUE_PREDECODE_EN
   import rv_decode_pkg::*;
`endif

   localparam int                PTR_W    = $clog2(DEPTH);
   localparam int                CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

   logic [ADDR_WIDTH-1:0] pc_mem_q   [DEPTH];
   logic [ADDR_WIDTH-1:0] pc_mem_d   [DEPTH];
   logic [INST_WIDTH-1:0] inst_mem_q [DEPTH];
   logic [INST_WIDTH-1:0] inst_mem_d [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q,  count_d;

   logic in_ready_w;
   logic out_valid_w;
   logic do_enq;
   logic do_deq;

   // in_ready deliberately ignores out_ready: a full queue never accepts
   assign in_ready_w  = !rst && (count_q != FULL_CNT);
   assign out_valid_w = (count_q != '0);
   assign do_enq      = q.in_valid && in_ready_w;
   assign do_deq      = out_valid_w && q.out_ready;

`ifdef IF_ID_QUEUE_PREDECODE_EN
   imm_type_t imm_mem_q [DEPTH];
   imm_type_t imm_mem_d [DEPTH];
   imm_type_t in_imm_type;

   if_id_predecode u_predecode (
      .opcode   (q.in_inst[6:0]),
      .imm_type (in_imm_type)
   );
`endif

   always_comb begin
      pc_mem_d   = pc_mem_q;
      inst_mem_d = inst_mem_q;
`ifdef IF_ID_QUEUE_PREDECODE_EN
      imm_mem_d  = imm_mem_q;
`endif
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_enq) begin
            pc_mem_d[wr_ptr_q]   = q.in_pc;
            inst_mem_d[wr_ptr_q] = q.in_inst;
`ifdef IF_ID_QUEUE_PREDECODE_EN
            imm_mem_d[wr_ptr_q]  = in_imm_type;
`endif
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (do_deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (do_enq && !do_deq) begin
            count_d = count_q + CNT_W'(1);
         end else if (!do_enq && do_deq) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]   <= '0;
            inst_mem_q[i] <= '0;
`ifdef IF_ID_QUEUE_PREDECODE_EN
            imm_mem_q[i]  <= IMM_I_TYPE;
`endif
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         pc_mem_q   <= pc_mem_d;
         inst_mem_q <= inst_mem_d;
`ifdef IF_ID_QUEUE_PREDECODE_EN
         imm_mem_q  <= imm_mem_d;
`endif
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   assign q.in_ready  = in_ready_w;
   assign q.out_valid = out_valid_w;
   assign q.out_pc    = pc_mem_q[rd_ptr_q];
   assign q.out_inst  = inst_mem_q[rd_ptr_q];
`ifdef IF_ID_QUEUE_PREDECODE_EN
   assign q.out_imm_type = imm_mem_q[rd_ptr_q];
`endif
   assign count = count_q;

endmodule
`default_nettype wire
